// File: rtl/grayscale_stream_ctrl_if.sv
// Stream bundle between the grayscale frame sequencer and the DMA engines.
// Carries the RGB input stream and the packed gray output stream.
//
// Handshake: a beat transfers on a rising aclk edge where both tvalid and
// tready are high. A producer raises tvalid without waiting for tready and
// keeps tdata/tkeep/tlast stable until that transfer edge.
//
// The 'slave' modport is the controller side: it consumes s_rgb and produces
// m_gray. The 'master' modport is the environment (DMA) side.
interface grayscale_stream_ctrl_if #(
   parameter int LANES = 4
);
   logic [23:0]        s_rgb_tdata;
   logic               s_rgb_tvalid;
   logic               s_rgb_tready;
   logic [8*LANES-1:0] m_gray_tdata;
   logic [LANES-1:0]   m_gray_tkeep;
   logic               m_gray_tlast;
   logic               m_gray_tvalid;
   logic               m_gray_tready;

   modport slave (
      input  s_rgb_tdata, s_rgb_tvalid, m_gray_tready,
      output s_rgb_tready, m_gray_tdata, m_gray_tkeep, m_gray_tlast, m_gray_tvalid
   );

   modport master (
      output s_rgb_tdata, s_rgb_tvalid, m_gray_tready,
      input  s_rgb_tready, m_gray_tdata, m_gray_tkeep, m_gray_tlast, m_gray_tvalid
   );
endinterface

// File: rtl/grayscale_stream_ctrl.sv
// Frame-level sequencer around an external combinational RGB->gray converter.
// Feeds each accepted pixel to the converter, packs LANES gray bytes per
// output word (first pixel in lane 0), counts pixels against the programmed
// frame length and pulses done when the last word has been handed off.
// o_state exposes the FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE).
module grayscale_stream_ctrl #(
   parameter int PIX_CNT_W = 24,
   parameter int LANES     = 4
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic [PIX_CNT_W-1:0]  pixel_count,
   output logic                  busy,
   output logic                  done,
   output logic [23:0]           conv_rgb,
   input  logic [7:0]            conv_gray,
   output logic [1:0]            o_state,
   grayscale_stream_ctrl_if.slave bus
);

   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int DW     = 8 * LANES;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [PIX_CNT_W-1:0]  r_remaining;
   logic [LANE_W-1:0]     r_lane;
   logic [DW-1:0]         r_buf;
   logic [DW-1:0]         r_tdata;
   logic [LANES-1:0]      r_tkeep;
   logic                  r_tlast;
   logic                  r_tvalid;

   logic                  w_s_tready;
   logic                  w_accept;
   logic                  w_last_pix;
   logic                  w_word_done;
   logic [DW-1:0]         w_word;
   logic [LANES-1:0]      w_keep;

   // Input acceptance and word-completion conditions for the current cycle.
   always_comb begin
      w_s_tready  = (r_state == S_RUN) && (!r_tvalid || bus.m_gray_tready);
      w_accept    = w_s_tready && bus.s_rgb_tvalid;
      w_last_pix  = (r_remaining == PIX_CNT_W'(1));
      w_word_done = w_accept && ((r_lane == LANE_W'(LANES - 1)) || w_last_pix);
   end

   // Pack buffer with the current gray merged into lane r_lane; lanes above it stay zero.
   always_comb begin
      w_word = r_buf;
      w_keep = '0;
      for (int k = 0; k < LANES; k++) begin
         if (LANE_W'(k) == r_lane) w_word[8*k +: 8] = conv_gray;
         if (LANE_W'(k) <= r_lane) w_keep[k] = 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // FSM next-state logic; start outside IDLE is ignored.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (pixel_count != '0) ? S_RUN : S_DONE;
         S_RUN:   if (w_accept && w_last_pix) w_next = S_DRAIN;
         S_DRAIN: if (r_tvalid && bus.m_gray_tready && r_tlast) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Frame counter, lane pointer and pack buffer; cleared on each accepted start.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_remaining <= '0;
         r_lane      <= '0;
         r_buf       <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_remaining <= pixel_count;
         r_lane      <= '0;
         r_buf       <= '0;
      end else if (w_accept) begin
         r_remaining <= r_remaining - PIX_CNT_W'(1);
         r_lane      <= w_word_done ? '0 : r_lane + LANE_W'(1);
         r_buf       <= w_word_done ? '0 : w_word;
      end
   end

   // Output word register: loads on completion (even while handing off), else drops valid on handshake.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
      end else if (w_word_done) begin
         r_tdata  <= w_word;
         r_tkeep  <= w_keep;
         r_tlast  <= w_last_pix;
         r_tvalid <= 1'b1;
      end else if (bus.m_gray_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   // Status and stream outputs.
   always_comb begin
      busy              = (r_state == S_RUN) || (r_state == S_DRAIN);
      done              = (r_state == S_DONE);
      o_state           = r_state;
      conv_rgb          = bus.s_rgb_tdata;
      bus.s_rgb_tready  = w_s_tready;
      bus.m_gray_tdata  = r_tdata;
      bus.m_gray_tkeep  = r_tkeep;
      bus.m_gray_tlast  = r_tlast;
      bus.m_gray_tvalid = r_tvalid;
   end

endmodule

// File: tb/tb_grayscale_stream_ctrl.sv
// Bench for grayscale_stream_ctrl: directed frames, an external converter
// model, and a scoreboard that checks every output word as it is handed off.
module tb_grayscale_stream_ctrl;

   localparam int PIX_CNT_W = 24;
   localparam int LANES     = 4;
   localparam int W         = 8 * LANES + LANES + 1;

   logic                 aclk;
   logic                 aresetn;
   logic                 start;
   logic [PIX_CNT_W-1:0] pixel_count;
   logic                 busy;
   logic                 done;
   logic [23:0]          conv_rgb;
   logic [7:0]           conv_gray;
   logic [1:0]           o_state;

   grayscale_stream_ctrl_if #(.LANES(LANES)) s_if ();

   grayscale_stream_ctrl #(.PIX_CNT_W(PIX_CNT_W), .LANES(LANES)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .start       (start),
      .pixel_count (pixel_count),
      .busy        (busy),
      .done        (done),
      .conv_rgb    (conv_rgb),
      .conv_gray   (conv_gray),
      .o_state     (o_state),
      .bus         (s_if.slave)
   );

   // External converter model.
   function automatic logic [7:0] gray_of(input logic [23:0] p);
      int r, g, b;
      r = int'(p[23:16]);
      g = int'(p[15:8]);
      b = int'(p[7:0]);
      return 8'((299 * r + 587 * g + 114 * b) / 1000);
   endfunction
   assign conv_gray = gray_of(conv_rgb);

   // ---------------- clock / reset ----------------
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int cycle = 0;
   always @(posedge aclk) cycle++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [W-1:0]  exp_q[$];
   logic [23:0]   pix_q[$];
   int            done_cnt = 0;
   int            word_cnt = 0;
   int            tlast_cnt = 0;
   bit            gap_mode = 1'b0;
   int            last_hs = -1;
   bit            exp_done_next = 1'b0;
   bit            have_prev = 1'b0;
   logic [W-1:0]  prev_word;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge aclk) begin
      if (!aresetn) begin
         have_prev     = 1'b0;
         exp_done_next = 1'b0;
      end else begin
         if (exp_done_next) begin
            check("done_after_last", done, 1'b1);
            exp_done_next = 1'b0;
         end
         if (have_prev)
            check("hold_stable", {s_if.m_gray_tlast, s_if.m_gray_tkeep, s_if.m_gray_tdata}, prev_word);
         if (s_if.m_gray_tvalid && !s_if.m_gray_tready) begin
            have_prev = 1'b1;
            prev_word = {s_if.m_gray_tlast, s_if.m_gray_tkeep, s_if.m_gray_tdata};
         end else begin
            have_prev = 1'b0;
         end
         if (s_if.m_gray_tvalid && s_if.m_gray_tready) begin
            word_cnt++;
            if (s_if.m_gray_tlast) begin
               tlast_cnt++;
               exp_done_next = 1'b1;
            end
            if (exp_q.size() == 0) begin
               check("unexpected_word", {s_if.m_gray_tlast, s_if.m_gray_tkeep, s_if.m_gray_tdata}, '0);
            end else begin
               check("word", {s_if.m_gray_tlast, s_if.m_gray_tkeep, s_if.m_gray_tdata}, exp_q.pop_front());
            end
            if (gap_mode && last_hs >= 0) check("word_gap", cycle - last_hs, 4);
            last_hs = cycle;
         end
         if (done) done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic exp_word(input logic [31:0] data, input logic [3:0] keep, input logic last);
      exp_q.push_back({last, keep, data});
   endtask

   task automatic do_start(input int count);
      @(posedge aclk); #1;
      pixel_count = PIX_CNT_W'(count);
      start       = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
   endtask

   // Presents pix_q one pixel at a time; pops on each accepted beat.
   task automatic drive_pixels();
      int  guard;
      bit  hs;
      guard = 0;
      while (pix_q.size() > 0 && guard < 5000) begin
         s_if.s_rgb_tvalid = 1'b1;
         s_if.s_rgb_tdata  = pix_q[0];
         @(negedge aclk);
         hs = s_if.s_rgb_tready;
         @(posedge aclk); #1;
         if (hs) void'(pix_q.pop_front());
         guard++;
      end
      s_if.s_rgb_tvalid = 1'b0;
      s_if.s_rgb_tdata  = '0;
      check("drive_timeout", pix_q.size(), 0);
      pix_q.delete();
   endtask

   task automatic wait_done(input int target);
      int g;
      g = 0;
      while (done_cnt < target && g < 3000) begin
         @(negedge aclk);
         g++;
      end
      check("done_seen", done_cnt, target);
      repeat (3) @(negedge aclk);
      check("done_once", done_cnt, target);
      check("idle_after_done", {busy, o_state}, 3'b0);
      check("queue_drained", exp_q.size(), 0);
      @(posedge aclk); #1;
   endtask

   // ---------------- stimulus ----------------
   int exp_done;
   int wc_before;
   int tl_before;

   initial begin
      aresetn             = 1'b0;
      start               = 1'b0;
      pixel_count         = '0;
      s_if.s_rgb_tdata    = '0;
      s_if.s_rgb_tvalid   = 1'b0;
      s_if.m_gray_tready  = 1'b1;
      exp_done            = 0;
      repeat (3) @(posedge aclk);
      check("reset_outputs", {busy, done, s_if.s_rgb_tready, s_if.m_gray_tvalid, s_if.m_gray_tlast,
                              s_if.m_gray_tkeep, s_if.m_gray_tdata, o_state}, '0);
      #1 aresetn = 1'b1;

      // 1: four primaries in one word
      exp_word(32'h1D954CFF, 4'hF, 1'b1);
      pix_q = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};
      do_start(4);
      check("busy_after_start", busy, 1'b1);
      drive_pixels();
      exp_done++;
      wait_done(exp_done);

      // 2: partial final word
      exp_word(32'h80808080, 4'hF, 1'b0);
      exp_word(32'h00008080, 4'h3, 1'b1);
      for (int i = 0; i < 6; i++) pix_q.push_back(24'h808080);
      do_start(6);
      drive_pixels();
      exp_done++;
      wait_done(exp_done);

      // 3: downstream stall after the first word
      exp_word(32'h04030201, 4'hF, 1'b0);
      exp_word(32'h08070605, 4'hF, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         logic [7:0] v;
         v = 8'(i);
         pix_q.push_back({v, v, v});
      end
      s_if.m_gray_tready = 1'b0;
      do_start(8);
      fork
         drive_pixels();
         begin
            int g;
            g = 0;
            while (!s_if.m_gray_tvalid && g < 100) begin
               @(posedge aclk); #1;
               g++;
            end
            check("stall_word_ready", s_if.m_gray_tvalid, 1'b1);
            repeat (5) begin
               @(negedge aclk);
               check("stall_s_tready", s_if.s_rgb_tready, 1'b0);
            end
            @(posedge aclk); #1;
            s_if.m_gray_tready = 1'b1;
         end
      join
      exp_done++;
      wait_done(exp_done);

      // 4a: zero-length frame
      wc_before = word_cnt;
      do_start(0);
      @(negedge aclk);
      check("zero_done", {done, busy}, 2'b10);
      @(negedge aclk);
      check("zero_after", {done, busy, s_if.m_gray_tvalid}, 3'b000);
      check("zero_no_word", word_cnt, wc_before);
      exp_done++;
      check("zero_done_cnt", done_cnt, exp_done);

      // 4b: second start mid-frame is ignored
      exp_word(32'h40302010, 4'hF, 1'b1);
      pix_q = '{24'h101010, 24'h202020, 24'h303030, 24'h404040};
      do_start(4);
      fork
         drive_pixels();
         begin
            @(posedge aclk); #1;
            pixel_count = PIX_CNT_W'(2);
            start       = 1'b1;
            @(posedge aclk); #1;
            start = 1'b0;
         end
      join
      exp_done++;
      wait_done(exp_done);

      // 5: reset in the middle of a frame
      wc_before = word_cnt;
      pix_q = '{24'hFFFFFF, 24'hFF0000};
      do_start(4);
      drive_pixels();
      #3 aresetn = 1'b0;
      #1;
      check("midreset_outputs", {busy, done, s_if.s_rgb_tready, s_if.m_gray_tvalid, s_if.m_gray_tlast,
                                 s_if.m_gray_tkeep, s_if.m_gray_tdata, o_state}, '0);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      repeat (3) @(negedge aclk);
      check("midreset_no_done", done_cnt, exp_done);
      check("midreset_no_word", word_cnt, wc_before);
      exp_word(32'h4CFF0080, 4'hF, 1'b1);
      pix_q = '{24'h808080, 24'h000000, 24'hFFFFFF, 24'hFF0000};
      do_start(4);
      drive_pixels();
      exp_done++;
      wait_done(exp_done);

      // 6: long frame at full rate
      tl_before = tlast_cnt;
      wc_before = word_cnt;
      for (int w = 0; w < 256; w++) begin
         logic [31:0] d;
         for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'((4 * w + k) % 256);
         exp_word(d, 4'hF, (w == 255));
      end
      for (int i = 0; i < 1024; i++) begin
         logic [7:0] v;
         v = 8'(i % 256);
         pix_q.push_back({v, v, v});
      end
      gap_mode = 1'b1;
      last_hs  = -1;
      do_start(1024);
      drive_pixels();
      exp_done++;
      wait_done(exp_done);
      gap_mode = 1'b0;
      check("long_words", word_cnt - wc_before, 256);
      check("long_tlast", tlast_cnt - tl_before, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
